// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul job sequencer: default geometry and FSM encoding.
// The parent top level imports this too so it can size the engine and BRAMs to match.
package matmul_pkg;

    localparam int MM_DATA_WIDTH  = 32;
    localparam int MM_ADDR_WIDTH  = 12;
    localparam int MM_VECTOR_SIZE = 64;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD_X    = 3'd1,
        S_LOAD_Y    = 3'd2,
        S_RUN       = 3'd3,
        S_DRAIN_RD  = 3'd4,
        S_DRAIN_OUT = 3'd5,
        S_FINISH    = 3'd6
    } state_e;

    // Plain-vector aliases of the enum so older logic-typed state registers can compare against them
    localparam logic [2:0] ST_IDLE      = S_IDLE;
    localparam logic [2:0] ST_LOAD_X    = S_LOAD_X;
    localparam logic [2:0] ST_LOAD_Y    = S_LOAD_Y;
    localparam logic [2:0] ST_RUN       = S_RUN;
    localparam logic [2:0] ST_DRAIN_RD  = S_DRAIN_RD;
    localparam logic [2:0] ST_DRAIN_OUT = S_DRAIN_OUT;
    localparam logic [2:0] ST_FINISH    = S_FINISH;

    function automatic logic is_load_state(input logic [2:0] s);
        return (s == ST_LOAD_X) || (s == ST_LOAD_Y);
    endfunction

endpackage

// File: rtl/matmul_seq.sv
// Job sequencer for an N x N matrix multiply: streams X and Y into BRAM, kicks the engine,
// then drains Z back out one word at a time.
module matmul_seq
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH  = MM_DATA_WIDTH,
    parameter int ADDR_WIDTH  = MM_ADDR_WIDTH,
    parameter int VECTOR_SIZE = MM_VECTOR_SIZE
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  go,
    output logic                  busy,
    output logic                  job_done,

    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,

    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,

    output logic [ADDR_WIDTH-1:0] x_wr_addr,
    output logic [DATA_WIDTH-1:0] x_wr_din,
    output logic                  x_wr_en,

    output logic [ADDR_WIDTH-1:0] y_wr_addr,
    output logic [DATA_WIDTH-1:0] y_wr_din,
    output logic                  y_wr_en,

    output logic [ADDR_WIDTH-1:0] z_rd_addr,
    input  logic [DATA_WIDTH-1:0] z_rd_dout,

    output logic                  mm_start,
    input  logic                  mm_done
);

    localparam int WORDS = VECTOR_SIZE * VECTOR_SIZE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(WORDS - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  start_q, start_d;
    logic                  loaded_q, loaded_d;

    logic in_xfer;
    logic out_accept;
    logic cnt_last;

    assign in_ready   = is_load_state(state_q);
    assign in_xfer    = in_valid && in_ready;
    assign out_valid  = (state_q == ST_DRAIN_OUT) && loaded_q;
    assign out_accept = out_valid && out_ready;
    assign cnt_last   = (cnt_q == LAST_ADDR);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        out_data_d = out_data_q;
        start_d    = 1'b0;
        loaded_d   = loaded_q;

        case (state_q)
            ST_IDLE: begin
                if (go) begin
                    state_d = ST_LOAD_X;
                    cnt_d   = '0;
                end
            end

            ST_LOAD_X: begin
                if (in_xfer) begin
                    if (cnt_last) begin
                        state_d = ST_LOAD_Y;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_LOAD_Y: begin
                if (in_xfer) begin
                    if (cnt_last) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        start_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_RUN: begin
                if (mm_done) begin
                    state_d = ST_DRAIN_RD;
                    cnt_d   = '0;
                end
            end

            ST_DRAIN_RD: begin
                state_d  = ST_DRAIN_OUT;
                loaded_d = 1'b0;
            end

            // First DRAIN_OUT cycle is when the BRAM read data lands; capture it, then offer it.
            ST_DRAIN_OUT: begin
                if (!loaded_q) begin
                    out_data_d = z_rd_dout;
                    loaded_d   = 1'b1;
                end else if (out_accept) begin
                    if (cnt_last) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d = ST_DRAIN_RD;
                        cnt_d   = cnt_q + ADDR_WIDTH'(1);
                    end
                end
            end

            ST_FINISH: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            out_data_q <= '0;
            start_q    <= 1'b0;
            loaded_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            out_data_q <= out_data_d;
            start_q    <= start_d;
            loaded_q   <= loaded_d;
        end
    end

    assign busy     = (state_q != ST_IDLE);
    assign job_done = (state_q == ST_FINISH);
    assign mm_start = start_q;
    assign out_data = out_data_q;

    assign x_wr_addr = cnt_q;
    assign x_wr_din  = in_data;
    assign x_wr_en   = in_xfer && (state_q == ST_LOAD_X);

    assign y_wr_addr = cnt_q;
    assign y_wr_din  = in_data;
    assign y_wr_en   = in_xfer && (state_q == ST_LOAD_Y);

    assign z_rd_addr = cnt_q;

endmodule

// File: tb/tb_matmul_seq.sv
// Directed/randomized bench for matmul_seq at N=4 with behavioural X/Y/Z BRAMs and engine.
// The single main process drives inputs #1 after each rising edge and records writes on the falling edge.
module tb_matmul_seq;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int N  = 4;
    localparam int NN = N * N;

    typedef logic [DW-1:0] mat_t [NN];

    logic          clock;
    logic          reset;
    logic          go;
    logic          busy;
    logic          job_done;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] x_wr_addr;
    logic [DW-1:0] x_wr_din;
    logic          x_wr_en;
    logic [AW-1:0] y_wr_addr;
    logic [DW-1:0] y_wr_din;
    logic          y_wr_en;
    logic [AW-1:0] z_rd_addr;
    logic [DW-1:0] z_rd_dout;
    logic          mm_start;
    logic          mm_done;

    matmul_seq #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .VECTOR_SIZE(N)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .go       (go),
        .busy     (busy),
        .job_done (job_done),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_wr_addr(x_wr_addr),
        .x_wr_din (x_wr_din),
        .x_wr_en  (x_wr_en),
        .y_wr_addr(y_wr_addr),
        .y_wr_din (y_wr_din),
        .y_wr_en  (y_wr_en),
        .z_rd_addr(z_rd_addr),
        .z_rd_dout(z_rd_dout),
        .mm_start (mm_start),
        .mm_done  (mm_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [DW-1:0] xmem [2**AW];
    logic [DW-1:0] ymem [2**AW];
    logic [DW-1:0] zmem [2**AW];
    logic [DW-1:0] z_next;

    int checks;
    int fails;
    int x_count, y_count, x_addr_err, y_addr_err;
    int start_count, done_count;

    logic [DW-1:0] words [2*NN];
    mat_t          ref_z;

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: log what the DUT commits at this edge, then model the Z BRAM's registered read.
    task automatic tick();
        @(negedge clock);
        if (x_wr_en) begin
            xmem[x_wr_addr] = x_wr_din;
            if (x_wr_addr != AW'(x_count)) x_addr_err++;
            x_count++;
        end
        if (y_wr_en) begin
            ymem[y_wr_addr] = y_wr_din;
            if (y_wr_addr != AW'(y_count)) y_addr_err++;
            y_count++;
        end
        if (mm_start) start_count++;
        if (job_done) done_count++;
        z_next = zmem[z_rd_addr];
        @(posedge clock);
        #1;
        z_rd_dout = z_next;
    endtask

    function automatic mat_t mat_mul(input mat_t a, input mat_t b);
        mat_t r;
        for (int row = 0; row < N; row++) begin
            for (int col = 0; col < N; col++) begin
                logic [DW-1:0] acc;
                acc = '0;
                for (int k = 0; k < N; k++) acc += a[row*N+k] * b[k*N+col];
                r[row*N+col] = acc;
            end
        end
        return r;
    endfunction

    task automatic clear_counts();
        x_count = 0;  y_count = 0;
        x_addr_err = 0;  y_addr_err = 0;
        start_count = 0;  done_count = 0;
    endtask

    // Issue go and stream the 2*N*N words in words[]; optional bubbles and spurious go/mm_done.
    task automatic apply_stimulus(input int toggle, input int spurious, input int stop_after);
        int n;
        clear_counts();
        go = 1'b1;
        tick();
        go = 1'b0;
        check_output("busy_after_go", busy, 1);
        check_output("in_ready_load_x", in_ready, 1);
        for (int i = 0; i < stop_after; i++) begin
            if (toggle != 0) begin
                in_valid = 1'b0;
                in_data  = $urandom;
                tick();
            end
            in_valid = 1'b1;
            in_data  = words[i];
            if (spurious != 0 && i == 5)  mm_done = 1'b1;
            if (spurious != 0 && i == 20) go = 1'b1;
            n = 0;
            while (!in_ready && n < 20) begin
                tick();
                n++;
            end
            if (n == 20) check_output($sformatf("in_ready_timeout[%0d]", i), in_ready, 1);
            tick();
            mm_done = 1'b0;
            go      = 1'b0;
        end
    endtask

    task automatic run_job(input int toggle, input int spurious, input int stall_word, input string name);
        mat_t a, b, xs, ys;
        int n;
        apply_stimulus(toggle, spurious, 2*NN);
        in_valid = 1'b0;
        check_output({name, ":mm_start_pulse"}, mm_start, 1);
        check_output({name, ":x_writes"}, x_count, NN);
        check_output({name, ":y_writes"}, y_count, NN);
        check_output({name, ":x_addr_order"}, x_addr_err, 0);
        check_output({name, ":y_addr_order"}, y_addr_err, 0);
        for (int i = 0; i < NN; i++) begin
            a[i]  = words[i];
            b[i]  = words[NN+i];
            xs[i] = xmem[i];
            ys[i] = ymem[i];
            check_output($sformatf("%s:x_mem[%0d]", name, i), xmem[i], words[i]);
            check_output($sformatf("%s:y_mem[%0d]", name, i), ymem[i], words[NN+i]);
        end
        ref_z = mat_mul(a, b);
        begin
            mat_t zr;
            zr = mat_mul(xs, ys);
            for (int i = 0; i < NN; i++) zmem[i] = zr[i];
        end

        tick();
        check_output({name, ":mm_start_one_cycle"}, mm_start, 0);
        repeat (1 + $urandom_range(4)) begin
            tick();
            check_output({name, ":busy_run"}, busy, 1);
            check_output({name, ":out_valid_run"}, out_valid, 0);
        end
        check_output({name, ":start_count"}, start_count, 1);
        mm_done = 1'b1;
        tick();
        mm_done = 1'b0;

        for (int k = 0; k < NN; k++) begin
            n = 0;
            while (!out_valid && n < 10) begin
                tick();
                n++;
            end
            check_output($sformatf("%s:out_valid[%0d]", name, k), out_valid, 1);
            check_output($sformatf("%s:z_rd_addr[%0d]", name, k), z_rd_addr, k);
            check_output($sformatf("%s:out_data[%0d]", name, k), out_data, ref_z[k]);
            if (k == stall_word) begin
                repeat (5) begin
                    out_ready = 1'b0;
                    tick();
                    check_output($sformatf("%s:stall_valid[%0d]", name, k), out_valid, 1);
                    check_output($sformatf("%s:stall_data[%0d]", name, k), out_data, ref_z[k]);
                    check_output($sformatf("%s:stall_addr[%0d]", name, k), z_rd_addr, k);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check_output($sformatf("%s:drain_gap[%0d]", name, k), out_valid, 0);
        end
        check_output({name, ":job_done_pulse"}, job_done, 1);
        check_output({name, ":busy_finish"}, busy, 1);
        tick();
        check_output({name, ":job_done_low"}, job_done, 0);
        check_output({name, ":busy_idle"}, busy, 0);
        check_output({name, ":done_count"}, done_count, 1);
        tick();
        check_output({name, ":go_not_queued"}, busy, 0);
    endtask

    task automatic check_all_quiet(input string name);
        check_output({name, ":busy"}, busy, 0);
        check_output({name, ":job_done"}, job_done, 0);
        check_output({name, ":in_ready"}, in_ready, 0);
        check_output({name, ":out_valid"}, out_valid, 0);
        check_output({name, ":mm_start"}, mm_start, 0);
        check_output({name, ":x_wr_en"}, x_wr_en, 0);
        check_output({name, ":y_wr_en"}, y_wr_en, 0);
        check_output({name, ":out_data"}, out_data, 0);
        check_output({name, ":z_rd_addr"}, z_rd_addr, 0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks    = 0;
        fails     = 0;
        reset     = 1'b1;
        go        = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        mm_done   = 1'b0;
        z_rd_dout = '0;
        z_next    = '0;
        clear_counts();
        for (int i = 0; i < 2**AW; i++) begin
            xmem[i] = '0;
            ymem[i] = '0;
            zmem[i] = '0;
        end

        $display("[TB] reset state");
        repeat (3) tick();
        check_all_quiet("reset");
        reset = 1'b0;
        tick();
        check_all_quiet("after_reset");

        $display("[TB] in_valid while idle");
        in_valid = 1'b1;
        in_data  = 32'hDEAD_BEEF;
        mm_done  = 1'b1;
        repeat (3) tick();
        check_output("idle_in_ready", in_ready, 0);
        check_output("idle_no_x_writes", x_count, 0);
        check_output("idle_busy", busy, 0);
        in_valid = 1'b0;
        mm_done  = 1'b0;

        $display("[TB] full job, counting data");
        for (int i = 0; i < 2*NN; i++) words[i] = DW'(i + 1);
        run_job(0, 0, 3, "job_count");

        $display("[TB] load backpressure with random data");
        for (int i = 0; i < 2*NN; i++) words[i] = $urandom;
        run_job(1, 0, -1, "job_bubbles");

        $display("[TB] spurious go and mm_done");
        for (int i = 0; i < 2*NN; i++) words[i] = $urandom;
        run_job(0, 1, 7, "job_spurious");

        $display("[TB] reset mid-job");
        for (int i = 0; i < 2*NN; i++) words[i] = $urandom;
        apply_stimulus(0, 0, 10);
        check_output("midjob_x_writes", x_count, 10);
        reset = 1'b1;
        #1;
        check_all_quiet("midjob_reset");
        repeat (2) tick();
        check_output("midjob_no_more_writes", x_count, 10);
        check_all_quiet("midjob_reset_held");
        reset    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        check_output("midjob_idle_after", busy, 0);
        check_output("midjob_no_writes_after", x_count + y_count, 10);

        for (int i = 0; i < 2*NN; i++) words[i] = $urandom;
        run_job(0, 0, 15, "job_restart");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/matmul_seq.md
MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one matrix element.
REQ-002 Parameter ADDR_WIDTH, default 12, BRAM address width.
REQ-003 Parameter VECTOR_SIZE, default 64, matrix dimension N; N*N SHALL NOT exceed 2**ADDR_WIDTH.
REQ-004 clock  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 go  input  1  job request; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 job_done  output  1  one-cycle pulse after the last Z word is accepted.
REQ-009 in_data  input  DATA_WIDTH  host load word: X row-major, then Y row-major.
REQ-010 in_valid / in_ready  input / output  1 each  load-stream handshake.
REQ-011 out_data  output  DATA_WIDTH  Z result word, row-major.
REQ-012 out_valid / out_ready  output / input  1 each  drain-stream handshake.
REQ-013 x_wr_addr, x_wr_din, x_wr_en  output  ADDR_WIDTH, DATA_WIDTH, 1  X BRAM write port.
REQ-014 y_wr_addr, y_wr_din, y_wr_en  output  ADDR_WIDTH, DATA_WIDTH, 1  Y BRAM write port.
REQ-015 z_rd_addr  output  ADDR_WIDTH  Z BRAM read address; z_rd_dout  input  DATA_WIDTH  read data, valid one cycle after the address.
REQ-016 mm_start  output  1  one-cycle start pulse to the matmul engine; mm_done  input  1  engine completion.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD_X, LOAD_Y, RUN, DRAIN_RD, DRAIN_OUT and FINISH.
REQ-018 IDLE: go=1 -> LOAD_X with the word counter cleared; go=0 -> stay in IDLE.
REQ-019 A transfer SHALL occur only on a cycle with in_valid=1 and in_ready=1; in_ready SHALL be 1 only in LOAD_X and LOAD_Y.
REQ-020 LOAD_X: each transfer asserts x_wr_en with x_wr_addr=counter and x_wr_din=in_data in the same cycle, then increments the counter.
REQ-021 On the transfer at counter N*N-1, LOAD_X SHALL clear the counter and go to LOAD_Y.
REQ-022 LOAD_Y SHALL behave like LOAD_X using the Y port; on the transfer at counter N*N-1 it SHALL go to RUN and assert mm_start for exactly the next cycle.
REQ-023 RUN: wait for mm_done=1, then clear the counter and go to DRAIN_RD.
REQ-024 mm_done SHALL be ignored in every state other than RUN.
REQ-025 DRAIN_RD: drive z_rd_addr=counter, then go to DRAIN_OUT.
REQ-026 DRAIN_OUT: register z_rd_dout on entry and present it on out_data with out_valid=1, held stable until out_ready=1.
REQ-027 On acceptance in DRAIN_OUT: counter=N*N-1 -> FINISH; otherwise increment the counter and go to DRAIN_RD.
REQ-028 Drain throughput SHALL be one word per two cycles at most.
REQ-029 FINISH: assert job_done for one cycle, then go to IDLE.
REQ-030 go asserted while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-031 in_valid while in_ready=0 SHALL cause no write and no counter change.
REQ-032 The counter SHALL be ADDR_WIDTH bits and SHALL never wrap within a phase.
REQ-033 All BRAM enables, mm_start and out_valid SHALL be 0 outside their owning states.
REQ-034 Unreachable state encodings SHALL return the FSM to IDLE.

Reset
REQ-035 Reset SHALL force the FSM to IDLE and the counter and out_data to 0.
REQ-036 During and after reset, busy, job_done, in_ready, out_valid, mm_start and all write enables SHALL be 0.
REQ-037 Reset asserted mid-job SHALL abandon the job with no further BRAM writes; a new go SHALL be required.

Structure
REQ-038 The FSM state enum and the default DATA_WIDTH, ADDR_WIDTH and VECTOR_SIZE SHALL live in the shared package matmul_pkg.
REQ-039 No sub-module is required; the engine and the BRAMs SHALL be instantiated by the parent top level, not by matmul_seq.

Verification
REQ-040 Full job, N=4: go, then 32 words 1..32 with in_valid held high -> X addresses 0..15 hold 1..16 and Y addresses 0..15 hold 17..32; one mm_start pulse; after mm_done, 16 Z words drained in address order; a single job_done pulse.
REQ-041 Load backpressure: in_valid toggles every other cycle -> exactly 32 writes, addresses contiguous, no duplicates.
REQ-042 Drain stall: out_ready=0 for 5 cycles on word 3 -> out_data stable and out_valid=1 throughout; z_rd_addr not advanced.
REQ-043 Spurious inputs: go during LOAD_Y and mm_done during LOAD_X -> ignored; the job completes normally.
REQ-044 Reset mid-job: reset asserted after 10 X words -> all outputs 0 and FSM in IDLE; a following go restarts writes at X address 0.
